// File: rtl/cbus_arbiter_if.sv
// Cache-bus request/response types and the arbiter bus bundle.
// master: arbiter view; slave: requesters + memory view.
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

interface cbus_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
);
  import cbus_pkg::*;

  cbus_req_t  [NUM_REQ-1:0] ireqs;
  cbus_resp_t [NUM_REQ-1:0] oresps;
  cbus_req_t                oreq;
  cbus_resp_t               iresp;
  logic                     busy;
  logic [IDX_W-1:0]         grant_idx;

  modport master (
    input  ireqs,
    input  iresp,
    output oresps,
    output oreq,
    output busy,
    output grant_idx
  );

  modport slave (
    output ireqs,
    output iresp,
    input  oresps,
    input  oreq,
    input  busy,
    input  grant_idx
  );

endinterface

// File: rtl/cbus_arbiter.sv
// Shares one cache-bus port between NUM_REQ requesters, one whole
// transaction per grant. Ports: clk, resetn (async low), bus (master).
// Macro CBUS_ARB_FIXED_PRIO_EN: lowest index wins instead of round-robin.
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic            clk,
  input  logic            resetn,
  cbus_arbiter_if.master  bus
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] pick;
  logic             found;
  logic             release_ev;

`ifndef CBUS_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

  // Winner search; only consulted in IDLE, so BUSY never
  // depends on requester valids.
  always_comb begin
    logic [IDX_W-1:0] cand;
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef CBUS_ARB_FIXED_PRIO_EN
      cand = IDX_W'(i);
`else
      cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
`endif
      if (!found && bus.ireqs[cand].valid) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign release_ev = bus.iresp.ready && bus.iresp.last;

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
`ifndef CBUS_ARB_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = BUSY;
          grant_idx_d = pick;
        end
      end
      BUSY: begin
        if (release_ev) begin
          state_d  = IDLE;
`ifndef CBUS_ARB_FIXED_PRIO_EN
          rr_ptr_d = (grant_idx_q == IDX_W'(NUM_REQ - 1))
                   ? '0
                   : grant_idx_q + IDX_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
`ifndef CBUS_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
`ifndef CBUS_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  // Data path is pure muxing off registered state, so reset
  // blanks it in the same cycle.
  always_comb begin
    bus.oreq      = '0;
    bus.oresps    = '0;
    bus.busy      = (state_q == BUSY);
    bus.grant_idx = grant_idx_q;
    if (state_q == BUSY) begin
      bus.oreq                = bus.ireqs[grant_idx_q];
      bus.oresps[grant_idx_q] = bus.iresp;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter (round-robin build).
// Table of per-cycle vectors plus reset-mid-burst sequence.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  cbus_arbiter_if #(.NUM_REQ(2)) bus ();

  cbus_arbiter #(.NUM_REQ(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] v;
    logic       rdy;
    logic       lst;
    logic       eb;
    logic       eg;
    logic       eov;
    logic [1:0] erdy;
  } vec_t;

  vec_t tbl[$];
  vec_t sbq[$];

  logic [31:0] addrs [2];
  logic [31:0] rdata;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [1:0] v, logic rdy, logic lst,
                       logic [31:0] d);
    for (int i = 0; i < 2; i++) begin
      bus.ireqs[i]       = '0;
      bus.ireqs[i].valid = v[i];
      bus.ireqs[i].addr  = addrs[i];
      bus.ireqs[i].len   = 4'd3;
    end
    bus.iresp.ready = rdy;
    bus.iresp.last  = lst;
    bus.iresp.data  = d;
    rdata           = d;
  endtask

  task automatic add(logic [1:0] v, logic rdy, logic lst, logic eb,
                     logic eg, logic eov, logic [1:0] erdy);
    vec_t r;
    r.v = v; r.rdy = rdy; r.lst = lst; r.eb = eb;
    r.eg = eg; r.eov = eov; r.erdy = erdy;
    tbl.push_back(r);
  endtask

  task automatic check_vec(int n, vec_t e);
    logic own;
    chk($sformatf("busy[%0d]", n), 64'(bus.busy), 64'(e.eb));
    chk($sformatf("oreq_valid[%0d]", n), 64'(bus.oreq.valid),
        64'(e.eov));
    if (e.eb) begin
      chk($sformatf("grant[%0d]", n), 64'(bus.grant_idx), 64'(e.eg));
      chk($sformatf("oreq_addr[%0d]", n), 64'(bus.oreq.addr),
          64'(addrs[e.eg]));
    end else begin
      chk($sformatf("oreq_zero[%0d]", n), 64'(bus.oreq == '0), 64'd1);
    end
    for (int j = 0; j < 2; j++) begin
      own = e.eb && (e.eg == j[0]);
      chk($sformatf("rsp%0d_ready[%0d]", j, n),
          64'(bus.oresps[j].ready), 64'(e.erdy[j]));
      chk($sformatf("rsp%0d_last[%0d]", j, n),
          64'(bus.oresps[j].last), 64'(own ? e.lst : 1'b0));
      chk($sformatf("rsp%0d_data[%0d]", j, n),
          64'(bus.oresps[j].data), 64'(own ? rdata : 32'd0));
    end
  endtask

  initial begin
    vec_t e;
    addrs[0] = 32'h1000_0000;
    addrs[1] = 32'h8000_0040;

    // single-beat from req1 only
    add(2'b10, 0, 0, 0, 0, 0, 2'b00);
    add(2'b10, 1, 1, 1, 1, 1, 2'b10);
    add(2'b00, 0, 0, 0, 0, 0, 2'b00);
    // both valid, 4-beat burst for req0, req1 held off
    add(2'b11, 0, 0, 0, 0, 0, 2'b00);
    add(2'b11, 1, 0, 1, 0, 1, 2'b01);
    add(2'b11, 0, 0, 1, 0, 1, 2'b00);
    add(2'b11, 1, 0, 1, 0, 1, 2'b01);
    add(2'b11, 1, 0, 1, 0, 1, 2'b01);
    add(2'b11, 1, 1, 1, 0, 1, 2'b01);
    // bubble then req1, alternating afterwards
    add(2'b11, 0, 0, 0, 0, 0, 2'b00);
    add(2'b11, 1, 1, 1, 1, 1, 2'b10);
    add(2'b11, 0, 0, 0, 0, 0, 2'b00);
    add(2'b11, 1, 1, 1, 0, 1, 2'b01);
    add(2'b11, 0, 0, 0, 0, 0, 2'b00);
    add(2'b11, 1, 1, 1, 1, 1, 2'b10);
    add(2'b11, 0, 0, 0, 0, 0, 2'b00);
    add(2'b11, 1, 1, 1, 0, 1, 2'b01);
    add(2'b11, 0, 0, 0, 0, 0, 2'b00);
    add(2'b11, 1, 1, 1, 1, 1, 2'b10);
    // ready in IDLE ignored
    add(2'b00, 1, 1, 0, 0, 0, 2'b00);
    add(2'b00, 1, 0, 0, 0, 0, 2'b00);
    // owner drops valid; still waits for last
    add(2'b01, 0, 0, 0, 0, 0, 2'b00);
    add(2'b00, 0, 0, 1, 0, 0, 2'b00);
    add(2'b00, 1, 1, 1, 0, 0, 2'b01);
    add(2'b00, 0, 0, 0, 0, 0, 2'b00);

    resetn = 1'b0;
    drive(2'b00, 0, 0, 32'h0);
    #2;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_grant", 64'(bus.grant_idx), 64'd0);
    chk("rst_oreq", 64'(bus.oreq == '0), 64'd1);
    chk("rst_oresps", 64'(bus.oresps == '0), 64'd1);
    #10;
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].v, tbl[i].rdy, tbl[i].lst, 32'hD000_0000 | i);
      sbq.push_back(tbl[i]);
      #3;
      e = sbq.pop_front();
      check_vec(i, e);
    end

    // reset mid-burst while req1 owns the bus (rr_ptr=1 here)
    @(posedge clk); #1;
    drive(2'b11, 0, 0, 32'hA0);
    #2;
    chk("mb_idle", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    drive(2'b11, 1, 0, 32'hA1);
    #2;
    chk("mb_busy", 64'(bus.busy), 64'd1);
    chk("mb_grant", 64'(bus.grant_idx), 64'd1);
    @(posedge clk); #1;
    drive(2'b11, 1, 0, 32'hA2);
    resetn = 1'b0;
    #1;
    chk("mb_rst_busy", 64'(bus.busy), 64'd0);
    chk("mb_rst_oreq_valid", 64'(bus.oreq.valid), 64'd0);
    chk("mb_rst_oresps", 64'(bus.oresps == '0), 64'd1);
    #1;
    resetn = 1'b1;
    @(posedge clk); #2;
    chk("post_rst_busy", 64'(bus.busy), 64'd1);
    chk("post_rst_grant", 64'(bus.grant_idx), 64'd0);
    drive(2'b00, 1, 1, 32'h0);
    @(posedge clk); #2;
    chk("post_rst_release", 64'(bus.busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
